// File: rtl/ibex_rf_wb_buffer.sv
// Register-file write-side arbiter: EX results win, LSU loads bypass or queue in order.
// Optional ID-read forwarding is built only when IBEX_RF_WB_FWD_EN is defined.
module ibex_rf_wb_buffer #(
   parameter int unsigned DataWidth = 32,
   parameter bit          RV32E     = 1'b0,
   parameter int unsigned Depth     = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 ex_we_i,
   input  logic [4:0]           ex_waddr_i,
   input  logic [DataWidth-1:0] ex_wdata_i,
   input  logic                 lsu_valid_i,
   output logic                 lsu_ready_o,
   input  logic [4:0]           lsu_waddr_i,
   input  logic [DataWidth-1:0] lsu_wdata_i,
   output logic                 rf_we_o,
   output logic [4:0]           rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,
   input  logic [4:0]           raddr_a_i,
   input  logic [4:0]           raddr_b_i,
   output logic                 hazard_a_o,
   output logic                 hazard_b_o,
   output logic [DataWidth-1:0] fwd_a_o,
   output logic [DataWidth-1:0] fwd_b_o,
   output logic                 empty_o,
   output logic                 err_o
);

   localparam int unsigned     PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned     CntW     = $clog2(Depth + 1);
   localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
   localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      logic [PtrW-1:0] r;
      if (p == LastPtr) begin
         r = PtrW'(0);
      end else begin
         r = p + PtrW'(1);
      end
      return r;
   endfunction

   logic [Depth-1:0]     valid_q, valid_d;
   logic [4:0]           waddr_q [Depth];
   logic [4:0]           waddr_d [Depth];
   logic [DataWidth-1:0] wdata_q [Depth];
   logic [DataWidth-1:0] wdata_d [Depth];
   logic [PtrW-1:0]      head_q, head_d;
   logic [PtrW-1:0]      tail_q, tail_d;
   logic [CntW-1:0]      count_q, count_d;
   logic                 rf_we_q, rf_we_d;
   logic [4:0]           rf_waddr_q, rf_waddr_d;
   logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;
   logic                 err_q, err_d;

   logic ex_illegal_s, ex_write_s;
   logic lsu_ready_s, lsu_fire_s, lsu_illegal_s, lsu_write_s;
   logic buf_empty_s, pop_s, bypass_s, push_s, push_squash_s;
   logic [4:0] raddr_s [2];
   logic [1:0] hazard_s;

   // Writes to x0 and (in RV32E) to x16..x31 are dropped but still complete the handshake.
   assign ex_illegal_s  = RV32E & ex_we_i & ex_waddr_i[4];
   assign ex_write_s    = ex_we_i & (ex_waddr_i != 5'd0) & ~ex_illegal_s;
   assign lsu_ready_s   = (count_q < DepthCnt);
   assign lsu_fire_s    = lsu_valid_i & lsu_ready_s;
   assign lsu_illegal_s = RV32E & lsu_fire_s & lsu_waddr_i[4];
   assign lsu_write_s   = lsu_fire_s & (lsu_waddr_i != 5'd0) & ~lsu_illegal_s;
   assign buf_empty_s   = (count_q == CntW'(0));
   assign pop_s         = ~ex_we_i & ~buf_empty_s;
   assign bypass_s      = ~ex_we_i & buf_empty_s & lsu_fire_s;
   assign push_s        = lsu_write_s & ~bypass_s;
   assign push_squash_s = ex_write_s & (lsu_waddr_i == ex_waddr_i);
   assign err_d         = err_q | ex_illegal_s | lsu_illegal_s;

   // Output-stage arbitration: EX, then buffer head, then LSU bypass.
   always_comb begin
      if (ex_we_i) begin
         rf_we_d    = ex_write_s;
         rf_waddr_d = ex_waddr_i;
         rf_wdata_d = ex_wdata_i;
      end else if (pop_s) begin
         rf_we_d    = valid_q[head_q];
         rf_waddr_d = waddr_q[head_q];
         rf_wdata_d = wdata_q[head_q];
      end else if (bypass_s) begin
         rf_we_d    = lsu_write_s;
         rf_waddr_d = lsu_waddr_i;
         rf_wdata_d = lsu_wdata_i;
      end else begin
         rf_we_d    = 1'b0;
         rf_waddr_d = 5'd0;
         rf_wdata_d = '0;
      end
   end

   // Buffer update: EX squashes older entries to the same register, then pop, then push.
   always_comb begin
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      for (int unsigned i = 0; i < Depth; i++) begin
         valid_d[i] = valid_q[i] & ~(ex_write_s & (waddr_q[i] == ex_waddr_i));
      end
      if (pop_s) begin
         valid_d[head_q] = 1'b0;
         head_d          = ptr_inc(head_q);
      end else begin
         head_d = head_q;
      end
      if (push_s) begin
         valid_d[tail_q] = ~push_squash_s;
         waddr_d[tail_q] = lsu_waddr_i;
         wdata_d[tail_q] = lsu_wdata_i;
         tail_d          = ptr_inc(tail_q);
      end else begin
         tail_d = tail_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   assign raddr_s[0] = raddr_a_i;
   assign raddr_s[1] = raddr_b_i;

   // A read address is hazardous while any pending write to it is buffered or staged.
   always_comb begin
      for (int unsigned p = 0; p < 2; p++) begin
         hazard_s[p] = rf_we_q & (rf_waddr_q == raddr_s[p]);
         for (int unsigned i = 0; i < Depth; i++) begin
            hazard_s[p] = hazard_s[p] | (valid_q[i] & (waddr_q[i] == raddr_s[p]));
         end
         hazard_s[p] = hazard_s[p] & (raddr_s[p] != 5'd0);
      end
   end

   assign hazard_a_o = hazard_s[0];
   assign hazard_b_o = hazard_s[1];

`ifdef IBEX_RF_WB_FWD_EN
   logic [DataWidth-1:0] fwd_s [2];
   logic [PtrW-1:0]      fwd_idx_s;

   // Forward the newest pending value: walk the buffer oldest to newest over the stage value.
   always_comb begin
      fwd_idx_s = head_q;
      for (int unsigned p = 0; p < 2; p++) begin
         if (rf_we_q && (rf_waddr_q == raddr_s[p])) begin
            fwd_s[p] = rf_wdata_q;
         end else begin
            fwd_s[p] = '0;
         end
         fwd_idx_s = head_q;
         for (int unsigned k = 0; k < Depth; k++) begin
            if (valid_q[fwd_idx_s] && (waddr_q[fwd_idx_s] == raddr_s[p])) begin
               fwd_s[p] = wdata_q[fwd_idx_s];
            end else begin
               fwd_s[p] = fwd_s[p];
            end
            fwd_idx_s = ptr_inc(fwd_idx_s);
         end
      end
   end

   assign fwd_a_o = fwd_s[0];
   assign fwd_b_o = fwd_s[1];
`else
   assign fwd_a_o = '0;
   assign fwd_b_o = '0;
`endif

   // State registers; reset discards every buffered and staged write.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
         for (int unsigned i = 0; i < Depth; i++) begin
            waddr_q[i] <= 5'd0;
            wdata_q[i] <= '0;
         end
         head_q     <= PtrW'(0);
         tail_q     <= PtrW'(0);
         count_q    <= CntW'(0);
         rf_we_q    <= 1'b0;
         rf_waddr_q <= 5'd0;
         rf_wdata_q <= '0;
         err_q      <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         err_q      <= err_d;
      end
   end

   assign lsu_ready_o = lsu_ready_s;
   assign rf_we_o     = rf_we_q;
   assign rf_waddr_o  = rf_waddr_q;
   assign rf_wdata_o  = rf_wdata_q;
   assign empty_o     = buf_empty_s & ~rf_we_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_ibex_rf_wb_buffer.sv
// Directed bench for ibex_rf_wb_buffer: default instance plus an RV32E=1 instance on shared inputs.
module tb_ibex_rf_wb_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_we, lsu_valid;
   logic [4:0]  ex_waddr, lsu_waddr, raddr_a, raddr_b;
   logic [31:0] ex_wdata, lsu_wdata;

   logic        ready, rf_we, haz_a, haz_b, empty, err;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata, fwd_a, fwd_b;

   logic        e_ready, e_rf_we, e_haz_a, e_haz_b, e_empty, e_err;
   logic [4:0]  e_rf_waddr;
   logic [31:0] e_rf_wdata, e_fwd_a, e_fwd_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ibex_rf_wb_buffer #(.DataWidth(32), .RV32E(1'b0), .Depth(2)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
      .lsu_valid_i(lsu_valid), .lsu_ready_o(ready), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
      .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
      .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
      .hazard_a_o(haz_a), .hazard_b_o(haz_b), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
      .empty_o(empty), .err_o(err)
   );

   ibex_rf_wb_buffer #(.DataWidth(32), .RV32E(1'b1), .Depth(2)) u_e (
      .clk_i(clk), .rst_i(rst),
      .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
      .lsu_valid_i(lsu_valid), .lsu_ready_o(e_ready), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
      .rf_we_o(e_rf_we), .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata),
      .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
      .hazard_a_o(e_haz_a), .hazard_b_o(e_haz_b), .fwd_a_o(e_fwd_a), .fwd_b_o(e_fwd_b),
      .empty_o(e_empty), .err_o(e_err)
   );

   function automatic logic [31:0] fx(input logic [31:0] v);
`ifdef IBEX_RF_WB_FWD_EN
      return v;
`else
      return 32'h0 & v;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ex_we = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'h0;
      lsu_valid = 1'b0; lsu_waddr = 5'd0; lsu_wdata = 32'h0;
   endtask

   task automatic ex(input logic [4:0] a, input logic [31:0] d);
      ex_we = 1'b1; ex_waddr = a; ex_wdata = d;
   endtask

   task automatic lsu(input logic [4:0] a, input logic [31:0] d);
      lsu_valid = 1'b1; lsu_waddr = a; lsu_wdata = d;
   endtask

   initial begin
      rst = 1'b1; idle(); raddr_a = 5'd0; raddr_b = 5'd0;
      tick(); tick();
      chk("rst_we", {31'h0, rf_we}, 32'h0);
      chk("rst_waddr", {27'h0, rf_waddr}, 32'h0);
      chk("rst_wdata", rf_wdata, 32'h0);
      rst = 1'b0;
      tick();
      chk("idle_ready", {31'h0, ready}, 32'h1);
      chk("idle_empty", {31'h0, empty}, 32'h1);
      chk("idle_err", {31'h0, err}, 32'h0);
      chk("idle_e_err", {31'h0, e_err}, 32'h0);
      chk("idle_we", {31'h0, rf_we}, 32'h0);

      // LSU-only bypass
      lsu(5'd5, 32'hDEADBEEF);
      #1 chk("byp_ready", {31'h0, ready}, 32'h1);
      tick(); idle(); raddr_a = 5'd5; #1;
      chk("byp_we", {31'h0, rf_we}, 32'h1);
      chk("byp_waddr", {27'h0, rf_waddr}, 32'd5);
      chk("byp_wdata", rf_wdata, 32'hDEADBEEF);
      chk("byp_empty", {31'h0, empty}, 32'h0);
      chk("byp_haz", {31'h0, haz_a}, 32'h1);
      chk("byp_fwd", fwd_a, fx(32'hDEADBEEF));
      tick();
      chk("byp_we2", {31'h0, rf_we}, 32'h0);
      chk("byp_empty2", {31'h0, empty}, 32'h1);

      // EX/LSU conflict
      ex(5'd3, 32'h11); lsu(5'd7, 32'h22);
      tick(); idle(); raddr_a = 5'd7; raddr_b = 5'd3; #1;
      chk("cf_waddr1", {27'h0, rf_waddr}, 32'd3);
      chk("cf_wdata1", rf_wdata, 32'h11);
      chk("cf_haz_a", {31'h0, haz_a}, 32'h1);
      chk("cf_fwd_a", fwd_a, fx(32'h22));
      chk("cf_haz_b", {31'h0, haz_b}, 32'h1);
      chk("cf_fwd_b", fwd_b, fx(32'h11));
      chk("cf_ready", {31'h0, ready}, 32'h1);
      tick();
      chk("cf_we2", {31'h0, rf_we}, 32'h1);
      chk("cf_waddr2", {27'h0, rf_waddr}, 32'd7);
      chk("cf_wdata2", rf_wdata, 32'h22);
      tick();
      chk("cf_we3", {31'h0, rf_we}, 32'h0);
      chk("cf_empty3", {31'h0, empty}, 32'h1);

      // Fill the buffer while EX is busy
      ex(5'd1, 32'h1); lsu(5'd10, 32'hA0);
      tick();
      chk("full_w1", {27'h0, rf_waddr}, 32'd1);
      chk("full_rdy1", {31'h0, ready}, 32'h1);
      ex(5'd2, 32'h2); lsu(5'd11, 32'hA1);
      tick();
      chk("full_w2", {27'h0, rf_waddr}, 32'd2);
      chk("full_rdy2", {31'h0, ready}, 32'h0);
      ex(5'd3, 32'h3); lsu(5'd12, 32'hA2);
      tick();
      chk("full_w3", {27'h0, rf_waddr}, 32'd3);
      chk("full_rdy3", {31'h0, ready}, 32'h0);
      ex_we = 1'b0;
      tick();
      chk("full_d1_we", {31'h0, rf_we}, 32'h1);
      chk("full_d1_a", {27'h0, rf_waddr}, 32'd10);
      chk("full_d1_d", rf_wdata, 32'hA0);
      chk("full_rdy4", {31'h0, ready}, 32'h1);
      tick(); idle(); raddr_a = 5'd12; #1;
      chk("full_d2_a", {27'h0, rf_waddr}, 32'd11);
      chk("full_d2_d", rf_wdata, 32'hA1);
      chk("full_haz12", {31'h0, haz_a}, 32'h1);
      chk("full_fwd12", fwd_a, fx(32'hA2));
      tick();
      chk("full_d3_a", {27'h0, rf_waddr}, 32'd12);
      chk("full_d3_d", rf_wdata, 32'hA2);
      tick();
      chk("full_end_we", {31'h0, rf_we}, 32'h0);
      chk("full_end_empty", {31'h0, empty}, 32'h1);

      // WAW squash
      ex(5'd4, 32'h44); lsu(5'd9, 32'hAA);
      tick(); idle(); ex(5'd9, 32'hBB); raddr_a = 5'd9; #1;
      chk("sq_haz_buf", {31'h0, haz_a}, 32'h1);
      chk("sq_fwd_buf", fwd_a, fx(32'hAA));
      tick(); ex_we = 1'b0; #1;
      chk("sq_we", {31'h0, rf_we}, 32'h1);
      chk("sq_wdata", rf_wdata, 32'hBB);
      chk("sq_fwd_stage", fwd_a, fx(32'hBB));
      tick();
      chk("sq_pop_we", {31'h0, rf_we}, 32'h0);
      chk("sq_empty", {31'h0, empty}, 32'h1);

      // x0 writes
      ex(5'd0, 32'h5); raddr_b = 5'd0;
      tick(); idle();
      chk("x0_ex_we", {31'h0, rf_we}, 32'h0);
      chk("x0_haz_b", {31'h0, haz_b}, 32'h0);
      lsu(5'd0, 32'h77);
      tick(); idle();
      chk("x0_lsu_we", {31'h0, rf_we}, 32'h0);
      chk("x0_lsu_empty", {31'h0, empty}, 32'h1);

      // Reset mid-operation
      ex(5'd6, 32'h66); lsu(5'd8, 32'h88);
      tick(); idle(); raddr_a = 5'd8;
      #2 rst = 1'b1;
      #1;
      chk("mr_we", {31'h0, rf_we}, 32'h0);
      chk("mr_empty", {31'h0, empty}, 32'h1);
      chk("mr_haz", {31'h0, haz_a}, 32'h0);
      tick(); rst = 1'b0;
      tick();
      chk("mr_we2", {31'h0, rf_we}, 32'h0);
      chk("mr_ready", {31'h0, ready}, 32'h1);

      // RV32E illegal destinations
      lsu(5'd20, 32'h99);
      #1 chk("e_ready", {31'h0, e_ready}, 32'h1);
      tick(); idle();
      chk("e_lsu_we", {31'h0, e_rf_we}, 32'h0);
      chk("e_err1", {31'h0, e_err}, 32'h1);
      chk("m_x20_we", {31'h0, rf_we}, 32'h1);
      chk("m_x20_a", {27'h0, rf_waddr}, 32'd20);
      chk("m_err", {31'h0, err}, 32'h0);
      ex(5'd17, 32'h7);
      tick(); idle();
      chk("e_ex_we", {31'h0, e_rf_we}, 32'h0);
      chk("m_x17_a", {27'h0, rf_waddr}, 32'd17);
      ex(5'd0, 32'h5); raddr_b = 5'd0;
      tick(); idle();
      chk("e_x0_we", {31'h0, e_rf_we}, 32'h0);
      chk("e_x0_haz", {31'h0, e_haz_b}, 32'h0);
      chk("e_err_sticky", {31'h0, e_err}, 32'h1);
      chk("m_err2", {31'h0, err}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ibex_rf_wb_buffer.md
Name: ibex_rf_wb_buffer

Overview:
- Write-side driver for the flip-flop register file. It arbitrates register writebacks from two producers onto the single register-file write port.
  - EX: single-cycle ALU/CSR results, never back-pressured.
  - LSU: load-return data, valid/ready handshake.
- LSU results that lose arbitration wait in a small in-order buffer.
- Provides hazard detection and optional forwarding for the ID-stage read addresses, so reads never see stale data while a write is in flight.

Parameters:
DataWidth, 32, width of register data
RV32E, 0, 1: only x0..x15 are legal write targets
Depth, 2, LSU buffer entries (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
ex_we_i  in  1  EX writeback request (always accepted)
ex_waddr_i  in  5  EX destination register
ex_wdata_i  in  DataWidth  EX result
lsu_valid_i  in  1  load data valid
lsu_ready_o  out  1  buffer can accept load data
lsu_waddr_i  in  5  load destination register
lsu_wdata_i  in  DataWidth  load data
rf_we_o  out  1  register-file write enable (registered)
rf_waddr_o  out  5  register-file write address (registered)
rf_wdata_o  out  DataWidth  register-file write data (registered)
raddr_a_i  in  5  ID read address A
raddr_b_i  in  5  ID read address B
hazard_a_o  out  1  raddr_a_i has an in-flight write
hazard_b_o  out  1  raddr_b_i has an in-flight write
fwd_a_o  out  DataWidth  forwarded data for A
fwd_b_o  out  DataWidth  forwarded data for B
empty_o  out  1  buffer empty and no write in the output stage
err_o  out  1  illegal destination (RV32E, waddr[4]=1) seen, sticky

Behaviour:
- Reset (async, rst_i=1):
  - Buffer empty, all valid bits 0, count 0.
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, err_o=0.
  - After reset, lsu_ready_o=1 and empty_o=1.
  - Reset asserted mid-operation discards all buffered and staged writes; no write is emitted after reset.
- Output stage: one register (we/waddr/wdata). Fixed latency of 1 cycle from an accepted request to rf_we_o. The register file samples the stage on the following edge.
- Arbitration, evaluated each cycle in this priority order:
  1. ex_we_i=1: EX loads the output stage.
  2. Else, buffer head present: pop the head. If the head is valid, it loads the output stage. If the head was squashed, the stage gets we=0.
  3. Else, buffer empty and lsu_valid_i=1: the LSU bypasses directly into the output stage.
  4. Else, the stage gets we=0.
- LSU handshake:
  - lsu_ready_o = (count < Depth). It depends only on the registered count, never on a same-cycle pop.
  - A transfer occurs when valid&&ready.
  - A transfer not taken by bypass is pushed at the tail.
  - Push and pop in the same cycle leave count unchanged.
  - Full (count==Depth): lsu_ready_o=0 even if a pop occurs that cycle.
- x0:
  - Any write with waddr=0 is dropped: no output-stage write, no buffer push. It still completes the LSU handshake.
  - raddr=0 never raises a hazard.
- Squash (WAW): when EX writes address R, every buffered valid entry with waddr=R has its valid bit cleared in the same cycle, because EX is younger. A same-cycle LSU push to R is also squashed.
- Hazard:
  - hazard_x_o=1 if raddr_x_i!=0 and it matches any valid buffer entry, or the output stage with we=1.
  - Combinational.
- Forward priority: newest matching valid buffer entry, else the output stage, else '0.
- RV32E:
  - An EX or accepted LSU request with waddr[4]=1 sets err_o (sticky until reset).
  - The write is dropped.
  - With RV32E=0, err_o stays 0.
- empty_o = (count==0) && !rf_we_o.
- Pointers wrap modulo Depth; count is $clog2(Depth+1) bits.

Optional Feature:
- Macro: IBEX_RF_WB_FWD_EN.
- Defined: fwd_a_o/fwd_b_o are computed per the forward priority rule.
- Undefined: fwd_a_o/fwd_b_o are tied to '0 and the forwarding mux is not built. hazard_a_o/hazard_b_o are still generated, and ID must stall on them.

Test Plan:
- Reset then idle -> rf_we_o=0, lsu_ready_o=1, empty_o=1, err_o=0.
- LSU only: lsu x5=0xDEADBEEF with buffer empty -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF; the cycle after that rf_we_o=0.
- Conflict: same cycle ex x3=0x11 and lsu x7=0x22 -> cycle+1 writes x3=0x11; cycle+2 writes x7=0x22; raddr_a_i=7 at cycle+1 -> hazard_a_o=1, fwd_a_o=0x22.
- Full: Depth=2, EX busy every cycle, 3 LSU pushes -> lsu_ready_o=0 after the 2nd push; the 3rd is held until EX idles; writes drain in order.
- Squash: buffer holds x9=0xAA, then EX writes x9=0xBB -> only x9=0xBB is written; the buffered pop produces rf_we_o=0.
- RV32E=1: lsu x20 -> err_o=1 stays asserted, no write; ex x0=0x5 -> no write, hazard_b_o=0 for raddr_b_i=0.
